// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pkg
//  Purpose  : State encodings and Booth pair codes shared by the Booth
//             multiplier controller and its interface users.
//  Revision : 1.0  initial release
// ============================================================================
package booth_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LDM   = 3'd1;
    localparam state_t S_LDQ   = 3'd2;
    localparam state_t S_EXAM  = 3'd3;
    localparam state_t S_ARITH = 3'd4;
    localparam state_t S_SHIFT = 3'd5;
    localparam state_t S_DONE  = 3'd6;

    // {Q[0], Q[-1]} pairs that require an arithmetic step
    localparam logic [1:0] BP_SUB = 2'b10;
    localparam logic [1:0] BP_ADD = 2'b01;

    function automatic logic is_arith_pair(input logic [1:0] pair);
        return (pair == BP_SUB) || (pair == BP_ADD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_ctrl_if
//  Purpose  : Handshake, datapath status and datapath strobe bundle between
//             the Booth controller (master) and the datapath/requester (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface booth_ctrl_if;

    logic start;
    logic qm1;
    logic q0;
    logic eqz;
    logic busy;
    logic done;
    logic sel_q;
    logic ldA;
    logic ldQ;
    logic ldM;
    logic clrA;
    logic clrQ;
    logic clrff;
    logic sftA;
    logic sftQ;
    logic addsub;
    logic decr;
    logic ldcnt;

    modport master (
        input  start, qm1, q0, eqz,
        output busy, done, sel_q,
        output ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldcnt
    );

    modport slave (
        output start, qm1, q0, eqz,
        input  busy, done, sel_q,
        input  ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldcnt
    );

endinterface
`default_nettype wire

// File: rtl/booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : booth_ctrl
//  Purpose  : Moore controller sequencing a radix-2 Booth multiplier datapath:
//             operand load, WIDTH add/sub/shift iterations, done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int   WIDTH      = 16,
    parameter logic ADDSUB_ADD = 1'b1
) (
    input  wire          clk,
    input  wire          rst_n,
    booth_ctrl_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic       r_op;
    logic [1:0] w_pair;
    logic       w_arith_op;

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("booth_ctrl: WIDTH must be at least 2");
        end
    endgenerate

    assign w_pair     = {bus.q0, bus.qm1};
    assign w_arith_op = (w_pair == BP_SUB) ? ~ADDSUB_ADD : ADDSUB_ADD;

    // The operation is captured on entry to ARITH so addsub stays stable
    // while the datapath settles A+/-M.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_EXAM) && (w_next == S_ARITH)) begin
                r_op <= w_arith_op;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.start ? S_LDM : S_IDLE;
            S_LDM:   w_next = S_LDQ;
            S_LDQ:   w_next = S_EXAM;
            S_EXAM: begin
                if (bus.eqz) begin
                    w_next = S_DONE;
                end else if (is_arith_pair(w_pair)) begin
                    w_next = S_ARITH;
                end else begin
                    w_next = S_SHIFT;
                end
            end
            S_ARITH: w_next = S_SHIFT;
            S_SHIFT: w_next = S_EXAM;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (r_state != S_IDLE);
        bus.done   = 1'b0;
        bus.sel_q  = 1'b0;
        bus.ldA    = 1'b0;
        bus.ldQ    = 1'b0;
        bus.ldM    = 1'b0;
        bus.clrA   = 1'b0;
        bus.clrQ   = 1'b0;
        bus.clrff  = 1'b0;
        bus.sftA   = 1'b0;
        bus.sftQ   = 1'b0;
        bus.addsub = 1'b0;
        bus.decr   = 1'b0;
        bus.ldcnt  = 1'b0;
        case (r_state)
            S_LDM: begin
                bus.ldM   = 1'b1;
                bus.clrA  = 1'b1;
                bus.clrff = 1'b1;
                bus.ldcnt = 1'b1;
            end
            S_LDQ: begin
                bus.ldQ   = 1'b1;
                bus.sel_q = 1'b1;
            end
            S_ARITH: begin
                bus.ldA    = 1'b1;
                bus.addsub = r_op;
            end
            S_SHIFT: begin
                bus.sftA = 1'b1;
                bus.sftQ = 1'b1;
                bus.decr = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
